// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for a synchronous ROM with a
// 1-cycle read latency. Holds the PC, tracks the single request in flight
// and hands tagged instructions to decode. Supports a decode-side stall and
// an execute-side redirect.
// Optional feature: define FETCH_JUMP_EN to predecode opcode 4'b0110 as a
// PC-relative jump and redirect locally.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_valid_q;

    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] target;
    logic              take_redirect;
    logic              squash;
    logic              jump_fire;
    logic              jump_q;

    // Instructions live at even addresses, so the redirect target drops bit 0
    assign redirect_target = redirect_pc & ~ADDR_W'(1);

`ifdef FETCH_JUMP_EN
    logic [12:0]       jump_off13;
    logic [ADDR_W-1:0] jump_target;

    assign jump_off13  = {instr[11:0], 1'b0};
    assign jump_target = instr_pc + STEP + {{(ADDR_W-13){jump_off13[12]}}, jump_off13};
    assign jump_fire   = instr_valid & ~stall & (instr[15:12] == 4'b0110) & ~redirect_valid;

    // Remember a taken local jump so the word after it is dropped and re-read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 jump_q <= 1'b0;
        else if (redirect_valid) jump_q <= 1'b0;
        else if (stall)          jump_q <= jump_q;
        else                     jump_q <= jump_fire;
    end

    assign target = redirect_valid ? redirect_target : jump_target;
`else
    assign jump_fire = 1'b0;
    assign jump_q    = 1'b0;
    assign target    = redirect_target;
`endif

    assign take_redirect = redirect_valid | jump_fire;
    assign squash        = redirect_valid | jump_q;

    assign instr_valid = req_valid_q & ~squash;
    assign instr_pc    = req_pc_q;
    assign instr       = imem_rdata;

    // Address selection: redirect target, re-read of the held word, or next PC
    always_comb begin
        imem_addr = pc_q;
        if (take_redirect)
            imem_addr = target;
        else if ((stall || jump_q) && state != BOOT)
            imem_addr = req_pc_q;
    end

    // PC, in-flight request tracking and BOOT/RUN/HOLD sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            state       <= BOOT;
        end else if (take_redirect) begin
            req_pc_q    <= target;
            req_valid_q <= 1'b1;
            pc_q        <= target + STEP;
            state       <= RUN;
        end else if (stall) begin
            state       <= (state == BOOT) ? BOOT : HOLD;
        end else if (jump_q) begin
            state       <= RUN;
        end else begin
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= pc_q + STEP;
            state       <= RUN;
        end
    end

endmodule
